// File: rtl/spi_peripheral_if.sv
// Parallel-side handshake and SPI pin bundle for spi_peripheral.
// The slave modport is the peripheral's view; master is the driving environment.
interface spi_peripheral_if;
  logic [1:0] i_spi_mode;
  logic [7:0] i_tx;
  logic       i_tx_valid;
  logic       o_tx_ready;
  logic [7:0] o_rx;
  logic       o_rx_valid;
  logic       o_underrun;
  logic       o_busy;
  logic       i_sclk;
  logic       i_cs_n;
  logic       i_copi;
  logic       o_cipo;
  logic       o_cipo_oe;

  modport slave (
    input  i_spi_mode, i_tx, i_tx_valid, i_sclk, i_cs_n, i_copi,
    output o_tx_ready, o_rx, o_rx_valid, o_underrun, o_busy, o_cipo, o_cipo_oe
  );

  modport master (
    output i_spi_mode, i_tx, i_tx_valid, i_sclk, i_cs_n, i_copi,
    input  o_tx_ready, o_rx, o_rx_valid, o_underrun, o_busy, o_cipo, o_cipo_oe
  );
endinterface

// File: rtl/spi_peripheral.sv
// 8-bit SPI responder, all four modes, MSB first, oversampled on i_clk.
// One-deep TX holding register in front of the shifter; RX byte strobed on completion.
module spi_peripheral #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  spi_peripheral_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  state_e r_state, w_state_next;

  logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_copi_sync;
  logic                   r_sclk_d, r_cs_d;
  logic [1:0]             r_mode;
  logic [2:0]             r_bit_cnt;
  logic [7:0]             r_tx_shift, r_rx_shift, r_hold, r_rx;
  logic                   r_hold_full, r_rx_valid, r_underrun;

  logic w_sclk, w_cs_n, w_copi;
  logic w_sclk_rise, w_sclk_fall, w_lead, w_trail;
  logic w_sample_edge, w_shift_edge, w_cs_fall, w_cs_rise;
  logic w_start, w_load, w_shift, w_sample, w_wr;

  // cs_n synchronizer resets to deasserted so reset release never looks like a frame start
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sclk_sync <= '0;
      r_cs_sync   <= '1;
      r_copi_sync <= '0;
      r_sclk_d    <= 1'b0;
      r_cs_d      <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], bus.i_sclk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], bus.i_cs_n};
      r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], bus.i_copi};
      r_sclk_d    <= w_sclk;
      r_cs_d      <= w_cs_n;
    end
  end

  assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs_n = r_cs_sync[SYNC_STAGES-1];
  assign w_copi = r_copi_sync[SYNC_STAGES-1];

  assign w_sclk_rise   = w_sclk & ~r_sclk_d;
  assign w_sclk_fall   = ~w_sclk & r_sclk_d;
  assign w_lead        = r_mode[1] ? w_sclk_fall : w_sclk_rise;
  assign w_trail       = r_mode[1] ? w_sclk_rise : w_sclk_fall;
  assign w_sample_edge = r_mode[0] ? w_trail : w_lead;
  assign w_shift_edge  = r_mode[0] ? w_lead : w_trail;
  assign w_cs_fall     = r_cs_d & ~w_cs_n;
  assign w_cs_rise     = ~r_cs_d & w_cs_n;
  assign w_wr          = bus.i_tx_valid & ~r_hold_full;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    w_sample     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_cs_fall) begin
          w_state_next = StActive;
          w_start      = 1'b1;
          w_load       = ~bus.i_spi_mode[0];
        end
      end
      StActive: begin
        if (w_cs_rise) begin
          w_state_next = StIdle;
        end else begin
          // bit_cnt==0 on a shift edge marks a byte boundary in either phase
          if (w_shift_edge) begin
            w_load  = (r_bit_cnt == 3'd0);
            w_shift = (r_bit_cnt != 3'd0);
          end
          w_sample = w_sample_edge;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mode      <= 2'b00;
      r_bit_cnt   <= 3'd0;
      r_tx_shift  <= 8'h00;
      r_rx_shift  <= 8'h00;
      r_hold      <= 8'h00;
      r_hold_full <= 1'b0;
      r_rx        <= 8'h00;
      r_rx_valid  <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_underrun <= 1'b0;
      if (w_start) begin
        r_mode    <= bus.i_spi_mode;
        r_bit_cnt <= 3'd0;
        r_tx_shift <= 8'h00;
      end
      if (w_load) begin
        if (r_hold_full) begin
          r_tx_shift  <= r_hold;
          r_hold_full <= 1'b0;
        end else begin
          r_tx_shift <= 8'hFF;
          r_underrun <= 1'b1;
        end
      end else if (w_shift) begin
        r_tx_shift <= {r_tx_shift[6:0], 1'b0};
      end
      if (w_sample) begin
        r_rx_shift <= {r_rx_shift[6:0], w_copi};
        r_bit_cnt  <= r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) begin
          r_rx       <= {r_rx_shift[6:0], w_copi};
          r_rx_valid <= 1'b1;
        end
      end
      // A write only lands when hold is empty, so it never collides with a consuming LOAD
      if (w_wr) begin
        r_hold      <= bus.i_tx;
        r_hold_full <= 1'b1;
      end
    end
  end

  assign bus.o_tx_ready = ~r_hold_full;
  assign bus.o_rx       = r_rx;
  assign bus.o_rx_valid = r_rx_valid;
  assign bus.o_underrun = r_underrun;
  assign bus.o_busy     = (r_state == StActive);
  assign bus.o_cipo_oe  = (r_state == StActive);
  assign bus.o_cipo     = (r_state == StActive) & r_tx_shift[7];

endmodule

// File: tb/tb_spi_peripheral.sv
// Bench for spi_peripheral: a bit-level SPI controller plus a frame-level model of the
// one-deep holding register predicting what the controller receives and when underruns occur.
module tb_spi_peripheral;
  localparam int unsigned SYNC = 2;
  localparam int HALF = 6;

  logic clk = 1'b0;
  logic rst;
  spi_peripheral_if bus ();

  spi_peripheral #(.SYNC_STAGES(SYNC)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int         mon_rxv = 0;
  int         mon_ur  = 0;
  logic [7:0] rx_hist[$];

  always @(negedge clk) begin
    if (bus.o_rx_valid === 1'b1) begin
      mon_rxv++;
      rx_hist.push_back(bus.o_rx);
    end
    if (bus.o_underrun === 1'b1) mon_ur++;
  end

  logic [7:0] m_out[4];
  logic [7:0] m_in[4];
  logic [7:0] feed_q[$];
  int         tick_no;
  int         wr_at = -1;
  logic [7:0] wr_byte;
  logic       rdy_snap;

  bit         m_full;
  logic [7:0] m_hold;
  logic [7:0] exp_b[4];
  int         exp_ur;

  // One i_clk step: optional timed write, otherwise refill hold from feed_q when ready
  task automatic tick();
    bus.i_tx_valid = 1'b0;
    if (wr_at >= 0 && tick_no == wr_at) begin
      bus.i_tx       = wr_byte;
      bus.i_tx_valid = 1'b1;
    end else if ((wr_at < 0 || tick_no > wr_at + 2) && feed_q.size() > 0 &&
                 bus.o_tx_ready === 1'b1) begin
      bus.i_tx       = feed_q.pop_front();
      bus.i_tx_valid = 1'b1;
    end
    if (wr_at >= 0 && tick_no == wr_at + 2) rdy_snap = bus.o_tx_ready;
    tick_no++;
    @(negedge clk);
  endtask

  task automatic do_frame(input logic [1:0] mode, input int nedges);
    int k;
    bus.i_spi_mode = mode;
    bus.i_sclk     = mode[1];
    bus.i_cs_n     = 1'b1;
    tick_no        = -4;
    repeat (4) tick();
    bus.i_cs_n = 1'b0;
    if (!mode[0]) bus.i_copi = m_out[0][7];
    repeat (HALF) tick();
    bus.i_spi_mode = 2'($urandom_range(3));
    for (int e = 0; e < nedges; e++) begin
      bus.i_sclk = ~bus.i_sclk;
      if (((e % 2) == 0) != mode[0]) begin
        k = e / 2;
        m_in[2'(k / 8)][3'(7 - (k % 8))] = bus.o_cipo;
      end else begin
        k = mode[0] ? e / 2 : e / 2 + 1;
        if (k < 32) bus.i_copi = m_out[2'(k / 8)][3'(7 - (k % 8))];
      end
      repeat (HALF) tick();
    end
    bus.i_cs_n = 1'b1;
    repeat (3 * HALF) tick();
    wr_at = -1;
    feed_q.delete();
    tick();
  endtask

  // Each LOAD takes hold if full, else 0xFF with an underrun; the feeder refills hold between loads.
  task automatic model_frame(input bit cpha, input int nbytes);
    logic [7:0] q[$];
    logic [7:0] v;
    int         loads;
    q      = feed_q;
    exp_ur = 0;
    loads  = nbytes + (cpha ? 0 : 1);
    for (int i = 0; i < loads; i++) begin
      if (!m_full && q.size() > 0) begin
        m_hold = q.pop_front();
        m_full = 1'b1;
      end
      if (m_full) begin
        v      = m_hold;
        m_full = 1'b0;
      end else begin
        v = 8'hFF;
        exp_ur++;
      end
      if (i < nbytes) exp_b[2'(i)] = v;
    end
    if (!m_full && q.size() > 0) begin
      m_hold = q.pop_front();
      m_full = 1'b1;
    end
  endtask

  task automatic test_reset();
    bus.i_spi_mode = 2'b00; bus.i_tx = 8'h00; bus.i_tx_valid = 1'b0;
    bus.i_sclk = 1'b0; bus.i_cs_n = 1'b1; bus.i_copi = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++; if (bus.o_tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_tx_ready got %b want 1", bus.o_tx_ready); end
    n_tests++; if (bus.o_rx !== 8'h00) begin n_fail++; $display("FAIL reset_rx got %h want 00", bus.o_rx); end
    n_tests++; if (bus.o_rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid got %b want 0", bus.o_rx_valid); end
    n_tests++; if (bus.o_underrun !== 1'b0) begin n_fail++; $display("FAIL reset_underrun got %b want 0", bus.o_underrun); end
    n_tests++; if (bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.o_busy); end
    n_tests++; if (bus.o_cipo !== 1'b0 || bus.o_cipo_oe !== 1'b0) begin n_fail++; $display("FAIL reset_cipo got %b/%b want 0/0", bus.o_cipo, bus.o_cipo_oe); end
    rst = 1'b0;
    m_full = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_mode0_basic();
    int v0, u0;
    m_out[0] = 8'h3C;
    feed_q = {8'hA5};
    model_frame(1'b0, 1);
    v0 = mon_rxv; u0 = mon_ur;
    do_frame(2'b00, 16);
    n_tests++; if (m_in[0] !== exp_b[0]) begin n_fail++; $display("FAIL m0_cipo got %h want %h", m_in[0], exp_b[0]); end
    n_tests++; if (bus.o_rx !== 8'h3C) begin n_fail++; $display("FAIL m0_rx got %h want 3c", bus.o_rx); end
    n_tests++; if (mon_rxv - v0 != 1) begin n_fail++; $display("FAIL m0_rx_valid_count got %0d want 1", mon_rxv - v0); end
    n_tests++; if (mon_ur - u0 != exp_ur) begin n_fail++; $display("FAIL m0_underrun got %0d want %0d", mon_ur - u0, exp_ur); end
    n_tests++; if (bus.o_tx_ready !== !m_full) begin n_fail++; $display("FAIL m0_tx_ready got %b want %b", bus.o_tx_ready, !m_full); end
  endtask

  task automatic test_modes();
    int v0, u0;
    for (int m = 1; m < 4; m++) begin
      m_out[0] = 8'h7E;
      feed_q = {8'h81};
      model_frame(m[0], 1);
      v0 = mon_rxv; u0 = mon_ur;
      do_frame(2'(m), 16);
      n_tests++; if (m_in[0] !== 8'h81) begin n_fail++; $display("FAIL mode%0d_cipo got %h want 81", m, m_in[0]); end
      n_tests++; if (bus.o_rx !== 8'h7E) begin n_fail++; $display("FAIL mode%0d_rx got %h want 7e", m, bus.o_rx); end
      n_tests++; if (mon_rxv - v0 != 1) begin n_fail++; $display("FAIL mode%0d_rx_valid_count got %0d want 1", m, mon_rxv - v0); end
      n_tests++; if (mon_ur - u0 != exp_ur) begin n_fail++; $display("FAIL mode%0d_underrun got %0d want %0d", m, mon_ur - u0, exp_ur); end
    end
  endtask

  task automatic test_back_to_back();
    int v0, u0, h0;
    logic [7:0] got;
    m_out[0] = 8'($urandom); m_out[1] = 8'($urandom);
    feed_q = {8'h11, 8'h22, 8'h33};
    model_frame(1'b0, 2);
    v0 = mon_rxv; u0 = mon_ur; h0 = rx_hist.size();
    do_frame(2'b00, 32);
    n_tests++; if (m_in[0] !== 8'h11 || m_in[1] !== 8'h22) begin n_fail++; $display("FAIL b2b_cipo got %h %h want 11 22", m_in[0], m_in[1]); end
    n_tests++; if (mon_rxv - v0 != 2) begin n_fail++; $display("FAIL b2b_rx_valid_count got %0d want 2", mon_rxv - v0); end
    n_tests++; if (mon_ur - u0 != 0) begin n_fail++; $display("FAIL b2b_underrun got %0d want 0", mon_ur - u0); end
    for (int j = 0; j < 2; j++) begin
      got = (rx_hist.size() > h0 + j) ? rx_hist[h0 + j] : 8'hxx;
      n_tests++; if (got !== m_out[j]) begin n_fail++; $display("FAIL b2b_rx%0d got %h want %h", j, got, m_out[j]); end
    end
  endtask

  task automatic test_underrun();
    int u0;
    logic [7:0] b;
    b = 8'($urandom);
    n_tests++; if (bus.o_tx_ready !== 1'b1) begin n_fail++; $display("FAIL ur_precondition_ready got %b want 1", bus.o_tx_ready); end
    m_out[0] = 8'($urandom); m_out[1] = 8'($urandom);
    wr_at = int'(SYNC); wr_byte = b; rdy_snap = 1'bx;
    feed_q = {8'($urandom)};
    u0 = mon_ur;
    do_frame(2'b00, 32);
    m_full = 1'b0;
    n_tests++; if (m_in[0] !== 8'hFF) begin n_fail++; $display("FAIL ur_first_byte got %h want ff", m_in[0]); end
    n_tests++; if (m_in[1] !== b) begin n_fail++; $display("FAIL ur_written_byte got %h want %h", m_in[1], b); end
    n_tests++; if (mon_ur - u0 != 1) begin n_fail++; $display("FAIL ur_pulse_count got %0d want 1", mon_ur - u0); end
    n_tests++; if (rdy_snap !== 1'b0) begin n_fail++; $display("FAIL ur_ready_after_write got %b want 0", rdy_snap); end
  endtask

  task automatic test_abort();
    int v0, u0;
    m_out[0] = 8'($urandom);
    feed_q = {8'($urandom)};
    model_frame(1'b0, 0);
    v0 = mon_rxv; u0 = mon_ur;
    do_frame(2'b00, 5);
    n_tests++; if (mon_rxv - v0 != 0) begin n_fail++; $display("FAIL abort_rx_valid got %0d want 0", mon_rxv - v0); end
    n_tests++; if (bus.o_cipo_oe !== 1'b0 || bus.o_busy !== 1'b0) begin n_fail++; $display("FAIL abort_idle got oe=%b busy=%b want 0 0", bus.o_cipo_oe, bus.o_busy); end
    n_tests++; if (mon_ur - u0 != 0) begin n_fail++; $display("FAIL abort_underrun got %0d want 0", mon_ur - u0); end
    m_out[0] = 8'($urandom);
    feed_q = {8'($urandom)};
    model_frame(1'b0, 1);
    v0 = mon_rxv;
    do_frame(2'b00, 16);
    n_tests++; if (m_in[0] !== exp_b[0]) begin n_fail++; $display("FAIL abort_next_cipo got %h want %h", m_in[0], exp_b[0]); end
    n_tests++; if (bus.o_rx !== m_out[0] || mon_rxv - v0 != 1) begin n_fail++; $display("FAIL abort_next_rx got %h x%0d want %h x1", bus.o_rx, mon_rxv - v0, m_out[0]); end
  endtask

  task automatic test_reset_midframe();
    int v0;
    logic [1:0] md;
    feed_q = {8'($urandom)};
    bus.i_spi_mode = 2'b00; bus.i_sclk = 1'b0; bus.i_cs_n = 1'b1;
    tick_no = -4; wr_at = -1;
    repeat (4) tick();
    bus.i_cs_n = 1'b0;
    repeat (HALF) tick();
    for (int e = 0; e < 3; e++) begin
      bus.i_sclk = ~bus.i_sclk;
      repeat (HALF) tick();
    end
    #2 rst = 1'b1;
    #1;
    n_tests++; if (bus.o_busy !== 1'b0 || bus.o_cipo_oe !== 1'b0 || bus.o_cipo !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle got busy=%b oe=%b cipo=%b want 0 0 0", bus.o_busy, bus.o_cipo_oe, bus.o_cipo); end
    n_tests++; if (bus.o_tx_ready !== 1'b1 || bus.o_rx !== 8'h00) begin n_fail++; $display("FAIL rstmid_regs got ready=%b rx=%h want 1 00", bus.o_tx_ready, bus.o_rx); end
    n_tests++; if (bus.o_rx_valid !== 1'b0 || bus.o_underrun !== 1'b0) begin n_fail++; $display("FAIL rstmid_strobes got %b %b want 0 0", bus.o_rx_valid, bus.o_underrun); end
    bus.i_cs_n = 1'b1; bus.i_sclk = 1'b0; bus.i_tx_valid = 1'b0;
    feed_q.delete();
    m_full = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    md = 2'($urandom_range(3));
    m_out[0] = 8'($urandom);
    feed_q = {8'($urandom)};
    model_frame(md[0], 1);
    v0 = mon_rxv;
    do_frame(md, 16);
    n_tests++; if (m_in[0] !== exp_b[0]) begin n_fail++; $display("FAIL rstmid_next_cipo mode%0d got %h want %h", md, m_in[0], exp_b[0]); end
    n_tests++; if (bus.o_rx !== m_out[0] || mon_rxv - v0 != 1) begin n_fail++; $display("FAIL rstmid_next_rx got %h x%0d want %h x1", bus.o_rx, mon_rxv - v0, m_out[0]); end
  endtask

  task automatic test_random();
    int v0, u0, h0, nb, nf;
    logic [1:0] md;
    logic [7:0] got;
    for (int it = 0; it < 8; it++) begin
      md = 2'($urandom_range(3));
      nb = int'($urandom_range(3, 1));
      nf = int'($urandom_range(nb + 1, 0));
      for (int j = 0; j < 4; j++) m_out[j] = 8'($urandom);
      for (int j = 0; j < nf; j++) feed_q.push_back(8'($urandom));
      model_frame(md[0], nb);
      v0 = mon_rxv; u0 = mon_ur; h0 = rx_hist.size();
      do_frame(md, 16 * nb);
      for (int j = 0; j < nb; j++) begin
        n_tests++; if (m_in[j] !== exp_b[j]) begin n_fail++; $display("FAIL rand%0d_cipo%0d mode%0d got %h want %h", it, j, md, m_in[j], exp_b[j]); end
        got = (rx_hist.size() > h0 + j) ? rx_hist[h0 + j] : 8'hxx;
        n_tests++; if (got !== m_out[j]) begin n_fail++; $display("FAIL rand%0d_rx%0d got %h want %h", it, j, got, m_out[j]); end
      end
      n_tests++; if (mon_rxv - v0 != nb) begin n_fail++; $display("FAIL rand%0d_rx_valid_count got %0d want %0d", it, mon_rxv - v0, nb); end
      n_tests++; if (mon_ur - u0 != exp_ur) begin n_fail++; $display("FAIL rand%0d_underrun got %0d want %0d", it, mon_ur - u0, exp_ur); end
      n_tests++; if (bus.o_tx_ready !== !m_full) begin n_fail++; $display("FAIL rand%0d_tx_ready got %b want %b", it, bus.o_tx_ready, !m_full); end
    end
  endtask

  initial begin
    test_reset();
    test_mode0_basic();
    test_modes();
    test_back_to_back();
    test_underrun();
    test_abort();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_peripheral.md
Name: spi_peripheral

Overview:
- 8-bit SPI peripheral (responder). It is the far end of the bus driven by spi_controller, for loopback benches and on-chip target emulation.
- Oversamples i_sclk, i_cs_n and i_copi on the system clock and supports all four SPI modes, MSB first.
- Parallel side: a one-deep TX holding register with a ready/valid handshake, and an RX byte output with a one-cycle valid strobe.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on i_sclk, i_cs_n and i_copi (minimum 2).

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  reset, asynchronous, active-high
- i_spi_mode  in  2  {CPOL, CPHA}; latched at chip-select assertion
- i_tx  in  8  next byte to return to the controller
- i_tx_valid  in  1  write strobe for i_tx
- o_tx_ready  out  1  TX holding register empty
- o_rx  out  8  last complete byte received
- o_rx_valid  out  1  one-cycle pulse when o_rx updates
- o_underrun  out  1  one-cycle pulse when a load found the holding register empty
- o_busy  out  1  frame in progress (synchronized chip select low)
- i_sclk  in  1  SPI clock from controller
- i_cs_n  in  1  chip select, active-low
- i_copi  in  1  controller-out data
- o_cipo  out  1  controller-in data
- o_cipo_oe  out  1  tristate enable for o_cipo

Behaviour:
- One clock domain, i_clk. i_rst asynchronously clears all state.
- Reset values: o_tx_ready=1; o_rx=0x00; o_rx_valid=0; o_underrun=0; o_busy=0; o_cipo=0; o_cipo_oe=0; holding register empty; bit_cnt=0.
- Synchronization: SYNC_STAGES flops per SPI input, plus one registered copy of synced sclk for edge detect.
- Edge decode: leading edge = rising if CPOL=0, falling if CPOL=1. Sample edge = leading if CPHA=0, trailing if CPHA=1. Shift edge = the other edge.
- Timing constraint: each SCLK half-period ≥ SYNC_STAGES+2 i_clk cycles, so SCLK ≤ i_clk/8 with the default. Behaviour above that rate is undefined.
- States: IDLE, ACTIVE.
  - IDLE→ACTIVE on synced cs_n falling edge: latch i_spi_mode, clear bit_cnt. If CPHA=0, perform a LOAD in the same cycle.
  - ACTIVE→IDLE on synced cs_n rising edge.
- LOAD operation:
  - Holding register full: tx_shift ← hold, hold marked empty.
  - Holding register empty: tx_shift ← 0xFF and o_underrun pulses for 1 cycle.
- Shift edge (ACTIVE only): if bit_cnt==0, LOAD; otherwise tx_shift ← {tx_shift[6:0],1'b0}. This one rule covers the first and subsequent bytes in both phases.
  - CPHA=1: the first leading edge performs the LOAD.
  - CPHA=0: the LOAD at chip-select assertion covers byte 0; the 8th trailing edge loads the next byte.
- Sample edge (ACTIVE only): rx_shift ← {rx_shift[6:0], copi_sync}; bit_cnt ← bit_cnt+1 (3-bit, wraps 7→0).
  - When the wrap occurs, the next cycle sets o_rx ← assembled byte and o_rx_valid=1 for exactly 1 cycle.
  - o_rx holds its value until the next completed byte.
- o_cipo = tx_shift[7] in ACTIVE. o_cipo_oe = 1 in ACTIVE, 0 in IDLE; o_cipo=0 in IDLE.
- Holding register:
  - i_tx_valid while o_tx_ready=1 captures i_tx and drops o_tx_ready on the next cycle.
  - i_tx_valid while o_tx_ready=0 is ignored.
  - o_tx_ready rises the cycle after a LOAD consumes the holding register.
  - Write and LOAD in the same cycle with hold empty: the LOAD takes 0xFF and flags underrun; the write is captured into hold.
- Multi-byte frames: cs_n stays low; bytes continue back to back; bit_cnt is not cleared between bytes.
- Mid-byte cs_n deassert: partial RX byte discarded (no o_rx_valid); tx_shift contents discarded; a byte already LOADed is not restored to hold.
- i_spi_mode changes while ACTIVE are ignored until the next chip-select assertion.
- SCLK edges while cs_n is high are ignored.
- o_busy = ACTIVE.

Test Plan:
- Mode 0, hold preloaded 0xA5; controller sends 0x3C in one 8-clock frame → o_cipo stream 1,0,1,0,0,1,0,1; o_rx=0x3C with one o_rx_valid pulse; o_tx_ready returns to 1 after chip-select falls.
- Modes 1, 2 and 3, each with hold=0x81 and controller byte=0x7E → controller receives 0x81; o_rx=0x7E; exactly one o_rx_valid per frame.
- Two-byte frame in mode 0; hold=0x11, refilled with 0x22 after o_tx_ready rises → controller receives 0x11 then 0x22; two o_rx_valid pulses; no o_underrun.
- Empty hold at frame start → controller receives 0xFF; o_underrun pulses once; a write in that same cycle lands in hold (o_tx_ready=0 afterwards).
- cs_n raised after 5 SCLK edges → no o_rx_valid; o_cipo_oe=0; next full frame receives correctly with bit_cnt restarted.
- Assert i_rst mid-frame → all outputs at reset values immediately (asynchronous); first frame after release behaves as frame 1.
